issue_scheduler: RTL and testbench

In-order issue controller that sits between the decoder and the execute stage of the scalar core. It accepts one decoded instruction per cycle and holds it back on RAW/WAW hazards against a scoreboard of outstanding scalar and predicate register writes, and on multiplier occupancy. It also serialises control flow (BR/CALL/RET) and sequences HALT to a quiescent stop.

---
 rtl/issue_scheduler.sv | 98 +++++++++
 tb/tb_issue_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/issue_scheduler.sv
// issue_scheduler: in-order issue gate with S/P scoreboard, MPY pacing and BR/CALL/RET/HALT sequencing.
// Optional macro SCOREBOARD_BYPASS_EN lets a same-cycle writeback clear hazards and the halt wait.
module issue_scheduler #(
    parameter  int MPY_CYCLES = 3,
    localparam int REG_SEL    = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dec_valid,
    output logic               dec_ready,
    input  logic [4:0]         opcode,
    input  logic               is_branch,
    input  logic               is_call,
    input  logic               is_ret,
    input  logic               halted,
    input  logic               a_from_regbank,
    input  logic               a_regbank_sel,
    input  logic [REG_SEL-1:0] a_regbank_addr,
    input  logic               b_from_regbank,
    input  logic               b_regbank_sel,
    input  logic [REG_SEL-1:0] b_regbank_addr,
    input  logic               z_writes,
    input  logic               z_regbank_sel,
    input  logic [REG_SEL-1:0] z_regbank_addr,
    input  logic               wb_valid,
    input  logic               wb_regbank_sel,
    input  logic [REG_SEL-1:0] wb_regbank_addr,
    input  logic               cf_resolve,
    output logic               issue_valid,
    output logic               stall,
    output logic               halted_out,
    output logic [1:0]         state
);
    localparam logic       S_REGS = 1'b0;
    localparam logic       P_REGS = 1'b1;
    localparam logic [4:0] OP_MPY = 5'h0C;

    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTING = 2'd2, HALTED = 2'd3} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_busy_s, w_busy_s, w_clr_s, w_set_s;
    logic [7:0]  r_busy_p, w_busy_p, w_clr_p, w_set_p;
    logic [3:0]  r_mpy_cnt;
    logic        w_is_mpy, w_raw_a, w_raw_b, w_waw, w_idle, w_issue;

    assign w_clr_s = (wb_valid && wb_regbank_sel == S_REGS) ? 32'd1 << wb_regbank_addr : 32'd0;
    assign w_clr_p = (wb_valid && wb_regbank_sel == P_REGS) ? 8'd1 << wb_regbank_addr[2:0] : 8'd0;
`ifdef SCOREBOARD_BYPASS_EN
    assign w_busy_s = r_busy_s & ~w_clr_s;
    assign w_busy_p = r_busy_p & ~w_clr_p;
`else
    assign w_busy_s = r_busy_s;
    assign w_busy_p = r_busy_p;
`endif

    assign w_is_mpy = opcode == OP_MPY;
    assign w_raw_a  = a_from_regbank &&
                      (a_regbank_sel == P_REGS ? w_busy_p[a_regbank_addr[2:0]] : w_busy_s[a_regbank_addr]);
    assign w_raw_b  = b_from_regbank &&
                      (b_regbank_sel == P_REGS ? w_busy_p[b_regbank_addr[2:0]] : w_busy_s[b_regbank_addr]);
    assign w_waw    = z_writes &&
                      (z_regbank_sel == P_REGS ? w_busy_p[z_regbank_addr[2:0]] : w_busy_s[z_regbank_addr]);
    assign w_idle   = ~|w_busy_s && ~|w_busy_p && r_mpy_cnt == 4'd0;

    always_comb begin
        dec_ready   = 1'b0;
        w_next      = r_state;
        dec_ready   = r_state == RUN && !w_raw_a && !w_raw_b && !w_waw && !(w_is_mpy && r_mpy_cnt != 4'd0);
        w_issue     = dec_valid && dec_ready;
        issue_valid = w_issue;
        stall       = dec_valid && !dec_ready;
        halted_out  = r_state == HALTED;
        state       = r_state;
        w_next      = (r_state == RUN && w_issue && halted)                           ? HALTING :
                      (r_state == RUN && w_issue && (is_branch || is_call || is_ret)) ? DRAIN   :
                      (r_state == DRAIN && cf_resolve)                                ? RUN     :
                      (r_state == HALTING && w_idle)                                  ? HALTED  : r_state;
    end

    // a set from this cycle's issue is OR-ed after the clear so it wins on a collision
    assign w_set_s = (w_issue && z_writes && z_regbank_sel == S_REGS) ? 32'd1 << z_regbank_addr : 32'd0;
    assign w_set_p = (w_issue && z_writes && z_regbank_sel == P_REGS) ? 8'd1 << z_regbank_addr[2:0] : 8'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RUN;
            r_busy_s  <= '0;
            r_busy_p  <= '0;
            r_mpy_cnt <= '0;
        end else begin
            r_state   <= w_next;
            r_busy_s  <= (r_busy_s & ~w_clr_s) | w_set_s;
            r_busy_p  <= (r_busy_p & ~w_clr_p) | w_set_p;
            r_mpy_cnt <= (w_issue && w_is_mpy) ? 4'(MPY_CYCLES - 1) :
                         (r_mpy_cnt != 4'd0)   ? r_mpy_cnt - 4'd1    : 4'd0;
        end
    end
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed and random stimulus checked against a set/array reference model.
module tb_issue_scheduler;
    localparam int         C      = 3;
    localparam logic [4:0] OP_ADD = 5'h01;
    localparam logic [4:0] OP_CMP = 5'h05;
    localparam logic [4:0] OP_MPY = 5'h0C;
    localparam logic [4:0] OP_BR  = 5'h10;
    localparam logic [4:0] OP_HLT = 5'h1F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, dec_valid = 1'b0, dec_ready;
    logic [4:0] opcode = '0;
    logic is_branch = 0, is_call = 0, is_ret = 0, halted = 0;
    logic a_from_regbank = 0, a_regbank_sel = 0, b_from_regbank = 0, b_regbank_sel = 0;
    logic [4:0] a_regbank_addr = '0, b_regbank_addr = '0, z_regbank_addr = '0, wb_regbank_addr = '0;
    logic z_writes = 0, z_regbank_sel = 0, wb_valid = 0, wb_regbank_sel = 0, cf_resolve = 0;
    logic issue_valid, stall, halted_out;
    logic [1:0] state;

    issue_scheduler #(.MPY_CYCLES(C)) dut (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_ready(dec_ready), .opcode(opcode),
        .is_branch(is_branch), .is_call(is_call), .is_ret(is_ret), .halted(halted),
        .a_from_regbank(a_from_regbank), .a_regbank_sel(a_regbank_sel), .a_regbank_addr(a_regbank_addr),
        .b_from_regbank(b_from_regbank), .b_regbank_sel(b_regbank_sel), .b_regbank_addr(b_regbank_addr),
        .z_writes(z_writes), .z_regbank_sel(z_regbank_sel), .z_regbank_addr(z_regbank_addr),
        .wb_valid(wb_valid), .wb_regbank_sel(wb_regbank_sel), .wb_regbank_addr(wb_regbank_addr),
        .cf_resolve(cf_resolve), .issue_valid(issue_valid), .stall(stall),
        .halted_out(halted_out), .state(state)
    );

    int total = 0, bad = 0, cyc = 0, last_mpy = -100, mstate = 0, iss_cyc = 0;
    bit fired;
    bit ms[32];
    bit mp[8];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // a register is pending unless a same-cycle writeback may count as cleared
    function automatic bit pending(input bit sel, input logic [4:0] a);
        bit b;
        b = sel ? mp[a[2:0]] : ms[a];
`ifdef SCOREBOARD_BYPASS_EN
        if (wb_valid && wb_regbank_sel == sel && (sel ? wb_regbank_addr[2:0] == a[2:0] : wb_regbank_addr == a))
            b = 0;
`endif
        return b;
    endfunction

    function automatic bit model_ready();
        return mstate == 0 && !(a_from_regbank && pending(a_regbank_sel, a_regbank_addr))
            && !(b_from_regbank && pending(b_regbank_sel, b_regbank_addr))
            && !(z_writes && pending(z_regbank_sel, z_regbank_addr))
            && !(opcode == OP_MPY && cyc - last_mpy < C);
    endfunction

    function automatic bit model_idle();
        bit q;
        q = cyc - last_mpy >= C;
        for (int i = 0; i < 32; i++) if (pending(1'b0, 5'(i))) q = 0;
        for (int i = 0; i < 8; i++) if (pending(1'b1, 5'(i))) q = 0;
        return q;
    endfunction

    task automatic step();
        bit r, iss, idl;
        #1;
        r   = model_ready();
        iss = dec_valid && r;
        idl = model_idle();
        check("dec_ready", 8'(dec_ready), 8'(r));
        check("issue_valid", 8'(issue_valid), 8'(iss));
        check("stall", 8'(stall), 8'(dec_valid && !r));
        check("state", 8'(state), 8'(mstate));
        check("halted_out", 8'(halted_out), 8'(mstate == 3));
        if (issue_valid === 1'b1) begin fired = 1; iss_cyc = cyc; end
        @(posedge clk);
        if (reset) begin
            foreach (ms[i]) ms[i] = 0;
            foreach (mp[i]) mp[i] = 0;
            mstate = 0; last_mpy = -100;
        end else begin
            if (wb_valid) begin
                if (wb_regbank_sel) mp[wb_regbank_addr[2:0]] = 0; else ms[wb_regbank_addr] = 0;
            end
            if (iss && z_writes) begin
                if (z_regbank_sel) mp[z_regbank_addr[2:0]] = 1; else ms[z_regbank_addr] = 1;
            end
            if (iss && opcode == OP_MPY) last_mpy = cyc;
            if (mstate == 0 && iss && halted) mstate = 2;
            else if (mstate == 0 && iss && (is_branch || is_call || is_ret)) mstate = 1;
            else if (mstate == 1 && cf_resolve) mstate = 0;
            else if (mstate == 2 && idl) mstate = 3;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic ins(input logic [4:0] op, input bit zw, input bit zs, input logic [4:0] za,
                       input bit af, input bit asl, input logic [4:0] aa,
                       input bit bf, input bit bsl, input logic [4:0] ba);
        dec_valid = 1; opcode = op; is_branch = op == OP_BR; is_call = 0; is_ret = 0; halted = op == OP_HLT;
        z_writes = zw; z_regbank_sel = zs; z_regbank_addr = za;
        a_from_regbank = af; a_regbank_sel = asl; a_regbank_addr = aa;
        b_from_regbank = bf; b_regbank_sel = bsl; b_regbank_addr = ba;
    endtask

    task automatic wb(input bit v, input bit sel, input logic [4:0] a);
        wb_valid = v; wb_regbank_sel = sel; wb_regbank_addr = a;
    endtask

    task automatic issue_wait(input int lim);
        fired = 0;
        for (int i = 0; i < lim && !fired; i++) step();
        check("issue_timeout", 8'(fired), 8'd1);
        dec_valid = 0;
    endtask

    task automatic drain_all();
        dec_valid = 0;
        for (int i = 0; i < 32; i++) begin wb(1, 0, 5'(i)); step(); end
        for (int i = 0; i < 8; i++) begin wb(1, 1, 5'(i)); step(); end
        wb(0, 0, 0);
        repeat (C) step();
    endtask

    initial begin
        int t1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        // RAW on S r3
        ins(OP_ADD, 1, 0, 3, 1, 0, 1, 1, 0, 2);
        issue_wait(1);
        ins(OP_ADD, 1, 0, 4, 1, 0, 3, 1, 0, 1);
        repeat (3) step();
        check("sub_stalled", 8'(stall), 8'd1);
        wb(1, 0, 3);
        fired = 0; step(); wb(0, 0, 0);
        if (!fired) issue_wait(2); else dec_valid = 0;
        // P scoreboard: S r2 busy, BR reads p2
        ins(OP_ADD, 1, 0, 2, 0, 0, 0, 0, 0, 0); issue_wait(1);
        ins(OP_CMP, 1, 1, 2, 0, 0, 0, 0, 0, 0); issue_wait(1);
        ins(OP_BR, 0, 0, 0, 1, 1, 2, 0, 0, 0);
        repeat (2) step();
        wb(1, 1, 2); fired = 0; step(); wb(0, 0, 0);
        if (!fired) issue_wait(2); else dec_valid = 0;
        repeat (5) begin step(); check("drain_state", 8'(state), 8'd1); end
        cf_resolve = 1; step(); cf_resolve = 0;
        ins(OP_ADD, 1, 0, 11, 0, 0, 0, 0, 0, 0); issue_wait(1);
        cf_resolve = 1; step(); cf_resolve = 0;
        check("resolve_in_run", 8'(state), 8'd0);
        // MPY pacing with an ADD in between
        ins(OP_MPY, 1, 0, 5, 0, 0, 0, 0, 0, 0); issue_wait(1); t1 = iss_cyc;
        ins(OP_ADD, 1, 0, 10, 0, 0, 0, 0, 0, 0); issue_wait(1);
        check("add_unblocked", 8'(iss_cyc - t1), 8'd1);
        ins(OP_MPY, 1, 0, 6, 0, 0, 0, 0, 0, 0); issue_wait(C + 2);
        check("mpy_gap", 8'(iss_cyc - t1), 8'(C));
        // issue and writeback of r9 in one cycle: set wins
        ins(OP_ADD, 1, 0, 9, 0, 0, 0, 0, 0, 0); wb(1, 0, 9);
        issue_wait(1); wb(0, 0, 0);
        ins(OP_ADD, 1, 0, 12, 1, 0, 9, 0, 0, 0);
        step(); step();
        check("r9_still_busy", 8'(stall), 8'd1);
        dec_valid = 0;
        drain_all();
        // HALT with r7 outstanding
        ins(OP_ADD, 1, 0, 7, 0, 0, 0, 0, 0, 0); issue_wait(1);
        ins(OP_HLT, 0, 0, 0, 0, 0, 0, 0, 0, 0); issue_wait(1);
        repeat (3) begin step(); check("halting_state", 8'(state), 8'd2); end
        wb(1, 0, 7); step(); wb(0, 0, 0);
        step();
        check("halted_state", 8'(state), 8'd3);
        check("halted_flag", 8'(halted_out), 8'd1);
        reset = 1; step(); reset = 0;
        step();
        check("post_reset_ready", 8'(dec_ready), 8'd1);
        check("post_reset_state", 8'(state), 8'd0);
        // random phase
        for (int n = 0; n < 3000; n++) begin
            int k;
            k = $urandom_range(0, 199);
            ins(k < 30 ? OP_MPY : k < 44 ? OP_BR : k < 46 ? OP_HLT : k < 100 ? OP_CMP : OP_ADD,
                k >= 46, k >= 46 && k < 100, 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
            is_call = k >= 190; is_ret = k == 189;
            if (k == 189) z_writes = 0;
            dec_valid = $urandom_range(0, 3) != 0;
            wb($urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom_range(0, 7)));
            cf_resolve = $urandom_range(0, 3) == 0;
            reset = $urandom_range(0, 199) == 0 || (mstate == 3 && $urandom_range(0, 7) == 0);
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
